// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and constants for the fetch stage and IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int unsigned XLEN = 32;

   // sll $0,$0,0 -- architecturally a no-op, used as the bubble encoding
   localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0000;

   typedef enum logic [2:0] {
      BOOT  = 3'd0,
      FETCH = 3'd1,
      WAIT  = 3'd2,
      DROP  = 3'd3,
      HOLD  = 3'd4
   } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Purpose  : IF/ID pipeline register with hold > load > bubble priority.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            hold_i,
   input  logic            load_i,
   input  logic            bubble_i,
   input  logic [XLEN-1:0] inst_i,
   input  logic [XLEN-1:0] pc_plus4_i,
   output logic [XLEN-1:0] inst_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic            valid_o
);

   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
   logic            valid_q, valid_d;

   always_comb begin
      inst_d     = inst_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      if (!hold_i) begin
         if (load_i) begin
            inst_d     = inst_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
         end else if (bubble_i) begin
            // pc_plus4 is left alone so decode keeps a sane branch base
            inst_d  = NOP_INST;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inst_q     <= NOP_INST;
         pc_plus4_q <= '0;
         valid_q    <= 1'b0;
      end else begin
         inst_q     <= inst_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   assign inst_o     = inst_q;
   assign pc_plus4_o = pc_plus4_q;
   assign valid_o    = valid_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_path.sv
`default_nettype none
// ============================================================================
// Module   : fetch_path
// Purpose  : Fetch stage (PC, stall-tolerant imem requests) plus IF/ID register.
//            Define FETCH_PERF_CNT_EN to add fetch_cnt/bubble_cnt counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_path
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INST     = NOP_INST_DEFAULT
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            stall_F,
   input  logic            stall_D,
   input  logic            pc_src_D,
   input  logic [XLEN-1:0] pc_br_D,
   input  logic            jump_D,
   input  logic [XLEN-1:0] pc_jump_D,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] inst_D,
   output logic [XLEN-1:0] pc_plus4_D,
   output logic            valid_D
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [XLEN-1:0] fetch_cnt,
   output logic [XLEN-1:0] bubble_cnt
`endif
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] skid_q, skid_d;

   logic            redirect_w;
   logic [XLEN-1:0] target_w;
   logic [XLEN-1:0] addr_plus4_w;
   logic            load_w;
   logic            bubble_w;
   logic            from_skid_w;
   logic [XLEN-1:0] load_inst_w;

   assign redirect_w   = (pc_src_D | jump_D) & ~stall_D;
   assign target_w     = pc_src_D ? pc_br_D : pc_jump_D;
   assign addr_plus4_w = addr_q + XLEN'(4);

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      skid_d      = skid_q;
      imem_req    = 1'b0;
      load_w      = 1'b0;
      bubble_w    = 1'b0;
      from_skid_w = 1'b0;

      case (state_q)
         BOOT: begin
            state_d = FETCH;
         end

         FETCH: begin
            imem_req = ~stall_F;
            if (redirect_w) begin
               pc_d     = target_w;
               bubble_w = 1'b1;
               if (imem_req && !imem_ready) begin
                  state_d = DROP;
               end
            end else if (imem_req && imem_ready) begin
               if (!stall_D) begin
                  load_w = 1'b1;
                  pc_d   = addr_plus4_w;
               end else begin
                  // decode is stalled: park the word rather than lose it
                  skid_d  = imem_rdata;
                  state_d = HOLD;
               end
            end else if (imem_req) begin
               state_d  = WAIT;
               bubble_w = ~stall_D;
            end else begin
               bubble_w = ~stall_D;
            end
         end

         WAIT: begin
            imem_req = 1'b1;
            if (redirect_w) begin
               pc_d     = target_w;
               bubble_w = 1'b1;
               state_d  = imem_ready ? FETCH : DROP;
            end else if (imem_ready) begin
               if (!stall_D) begin
                  load_w  = 1'b1;
                  pc_d    = addr_plus4_w;
                  state_d = FETCH;
               end else begin
                  skid_d  = imem_rdata;
                  state_d = HOLD;
               end
            end else begin
               bubble_w = ~stall_D;
            end
         end

         DROP: begin
            // wrong-path request must still complete before the new one starts
            imem_req = 1'b1;
            bubble_w = ~stall_D;
            if (redirect_w) begin
               pc_d = target_w;
            end
            if (imem_ready) begin
               state_d = FETCH;
            end
         end

         HOLD: begin
            if (redirect_w) begin
               pc_d     = target_w;
               bubble_w = 1'b1;
               state_d  = FETCH;
            end else if (!stall_D) begin
               load_w      = 1'b1;
               from_skid_w = 1'b1;
               pc_d        = addr_plus4_w;
               state_d     = FETCH;
            end
         end

         default: begin
            state_d = BOOT;
         end
      endcase

      // A fresh request always launches from the post-redirect PC
      addr_d = (state_d == FETCH) ? pc_d : addr_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         addr_q  <= RESET_VECTOR;
         skid_q  <= NOP_INST;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         skid_q  <= skid_d;
      end
   end

   assign imem_addr   = addr_q;
   assign load_inst_w = from_skid_w ? skid_q : imem_rdata;

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) u_if_id_reg (
      .clk        (clk),
      .reset_n    (reset_n),
      .hold_i     (stall_D),
      .load_i     (load_w),
      .bubble_i   (bubble_w),
      .inst_i     (load_inst_w),
      .pc_plus4_i (addr_plus4_w),
      .inst_o     (inst_D),
      .pc_plus4_o (pc_plus4_D),
      .valid_o    (valid_D)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [XLEN-1:0] fetch_cnt_q;
   logic [XLEN-1:0] bubble_cnt_q;

   // Strobes are already gated by stall_D, so they match real IF/ID writes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (load_w) begin
            fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
         end
         if (bubble_w && !load_w) begin
            bubble_cnt_q <= bubble_cnt_q + XLEN'(1);
         end
      end
   end

   assign fetch_cnt  = fetch_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule : fetch_path
`default_nettype wire

// File: doc/fetch_path.md
Name: fetch_path

Overview:
- Fetch stage plus IF/ID pipeline register, directly upstream of the decode stage.
- Owns the PC and drives a stall-tolerant instruction-memory request interface.
- Accepts branch/jump redirects from decode and delivers inst_D and pc_plus4_D (the decode branch adder's base) with a valid bit.
- Inserts NOP bubbles on memory wait, flush, or wrong-path drop.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0000, encoding injected as a bubble (sll $0,$0,0).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- stall_F  in  1  hazard unit: hold PC, issue no new request.
- stall_D  in  1  hazard unit: hold IF/ID contents.
- pc_src_D  in  1  branch taken in decode.
- pc_br_D  in  32  branch target.
- jump_D  in  1  jump in decode.
- pc_jump_D  in  32  jump target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  request completes this cycle; imem_rdata valid.
- imem_rdata  in  32  instruction word.
- inst_D  out  32  IF/ID instruction.
- pc_plus4_D  out  32  IF/ID PC+4.
- valid_D  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, any state): state=BOOT, pc_F=RESET_VECTOR, addr_q=RESET_VECTOR, inst_D=NOP_INST, pc_plus4_D=0, valid_D=0, imem_req=0.
- Redirect accepted = (pc_src_D|jump_D) & ~stall_D.
  - Target = pc_br_D if pc_src_D, else pc_jump_D; pc_src_D has priority.
  - Overrides stall_F.
  - Loads pc_F<=target and flushes IF/ID to a bubble.
- Bubble: inst_D=NOP_INST, valid_D=0, pc_plus4_D unchanged. Written only when ~stall_D.
- stall_D=1: IF/ID holds, and no flush occurs (a redirect is never accepted while stall_D=1).
- Load: inst_D<=imem_rdata, pc_plus4_D<=addr_q+4, valid_D<=1, pc_F<=addr_q+4. Arithmetic is mod 2^32; wrap at 32'hFFFF_FFFC gives 0.
- imem_addr is always addr_q. addr_q<=pc_F (post-redirect value) whenever a new request is launched from FETCH.
- States:
  - BOOT: req=0. Next state FETCH.
  - FETCH: req=~stall_F.
    - req & ready & ~stall_D & no redirect: Load; stay.
    - req & ~ready: go to WAIT; bubble if ~stall_D.
    - Redirect with no outstanding request (req=0 or ready=1): data discarded; stay.
    - Redirect with req & ~ready: go to DROP.
  - WAIT: req=1, address held.
    - ready & ~stall_D: Load; go to FETCH.
    - ready & stall_D: capture data into skid register; go to HOLD.
    - Redirect & ready: discard; go to FETCH.
    - Redirect & ~ready: go to DROP.
    - Otherwise: bubble each non-stalled cycle.
  - DROP: req=1 at the old address. Bubbles each non-stalled cycle.
    - ready: discard data; go to FETCH (next request uses pc_F).
    - Further redirect: pc_F<=new target; stay DROP.
  - HOLD: req=0.
    - ~stall_D: Load from skid; go to FETCH.
    - Redirect: discard skid; go to FETCH.
- Latency: one cycle from imem_ready to inst_D on a zero-wait, unstalled stream, giving one instruction per cycle.
- Zero-wait stall_F=1 & stall_D=0 with no redirect: the IF/ID register still receives a bubble.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- With it:
  - Adds output ports fetch_cnt (32) and bubble_cnt (32), both reset to 0.
  - fetch_cnt increments on every Load.
  - bubble_cnt increments on every bubble write.
  - Both wrap on overflow.
- Without it: neither the ports nor the logic exist.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {BOOT, FETCH, WAIT, DROP, HOLD}.
  - Constant NOP_INST default.
  - Width constant XLEN=32.
- Sub-module if_id_reg: async-reset register for inst/pc_plus4/valid with load, bubble and hold controls, where hold has priority.

Test Plan:
- Reset release, imem_ready=1 always: imem_addr 0,4,8; inst_D follows one cycle later with valid_D=1 and pc_plus4_D 4,8,12.
- imem_ready low 2 cycles at addr 8: two bubbles (valid_D=0), addr held at 8, then inst@8 loaded with pc_plus4_D=12.
- pc_src_D=1, pc_br_D=0x40 while WAIT at addr 0x10, ready returns 2 cycles later: data discarded, next request is 0x40, only bubbles in between.
- stall_D=1 when WAIT completes: HOLD entered; inst_D unchanged until stall_D drops, then skid word loaded with pc_plus4_D=addr+4.
- pc_src_D=1 and jump_D=1 with stall_D=1: redirect ignored. Same inputs with stall_D=0: PC=pc_br_D, since branch beats jump.
- Reset asserted mid-DROP: outputs return to reset values immediately; first request after release is RESET_VECTOR.
